// File: rtl/memory_spram_banked_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_spram_banked_wb: Wishbone B4 slave over BANKS 16K x 32 SPRAMs,      |
// | optional incremental bursts (MEMORY_SPRAM_BANKED_WB_BURST_EN).             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module memory_ice40_spram (
  input  logic        clk_i,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [13:0] addr_i,
  input  logic [3:0]  mask_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [31:0] r_mem [16384];

  // Output register holds its value on writes and idle cycles.
  always_ff @(posedge clk_i) begin
    if (cs_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (mask_i[b]) r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_o <= r_mem[addr_i];
      end
    end
  end
endmodule

module memory_spram_banked_wb #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int          BANKS        = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  input  logic [2:0]  cti_i,
  input  logic [1:0]  bte_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o
);
  localparam logic [31:0] c_region_bytes = 32'(BANKS) << 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef MEMORY_SPRAM_BANKED_WB_BURST_EN
    BURST  = 2'd2,
`endif
    SINGLE = 2'd1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_rbank;
  logic [31:0] w_rel;
  logic        w_hit;
  logic        w_req;
  logic        w_ack;
  logic        w_acc_en;
  logic        w_acc_we;
  logic [15:0] w_acc_word;
  logic [31:0] w_rdata [4];

  // An address below the base wraps to a value no smaller than the region size.
  assign w_rel = adr_i - BASE_ADDRESS;
  assign w_hit = (w_rel < c_region_bytes);
  assign w_req = cyc_i & stb_i;

`ifdef MEMORY_SPRAM_BANKED_WB_BURST_EN
  localparam logic [29:0] c_region_words = 30'(BANKS) << 14;
  logic        w_err;
  logic [29:0] w_next_word;
  logic        w_next_ok;
  assign w_next_word = w_rel[31:2] + 30'd1;
  assign w_next_ok   = (w_next_word < c_region_words);
  assign err_o       = w_err;
`else
  logic w_unused;
  assign w_unused = ^{cti_i, bte_i};
  assign err_o    = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_ack        = 1'b0;
    w_acc_en     = 1'b0;
    w_acc_we     = 1'b0;
    w_acc_word   = w_rel[17:2];
`ifdef MEMORY_SPRAM_BANKED_WB_BURST_EN
    w_err        = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_req && w_hit) begin
          w_acc_en = !we_i;
`ifdef MEMORY_SPRAM_BANKED_WB_BURST_EN
          if (cti_i == 3'b010 && bte_i == 2'b00) w_state_next = BURST;
          else                                   w_state_next = SINGLE;
`else
          w_state_next = SINGLE;
`endif
        end
      end
      SINGLE: begin
        w_state_next = IDLE;
        if (w_req && w_hit) begin
          w_ack    = 1'b1;
          w_acc_en = we_i;
          w_acc_we = we_i;
        end
      end
`ifdef MEMORY_SPRAM_BANKED_WB_BURST_EN
      BURST: begin
        if (!cyc_i) begin
          w_state_next = IDLE;
        end else if (stb_i) begin
          if (!w_hit) begin
            w_err        = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_ack = 1'b1;
            if (we_i) begin
              w_acc_en = 1'b1;
              w_acc_we = 1'b1;
            end else if (w_next_ok) begin
              // Fetch the following word so it is ready for the next beat.
              w_acc_en   = 1'b1;
              w_acc_word = w_next_word[15:0];
            end
            if (cti_i == 3'b111) w_state_next = IDLE;
          end
        end
      end
`endif
      default: w_state_next = IDLE;
    endcase
    if (!rst_ni) begin
      w_ack    = 1'b0;
      w_acc_en = 1'b0;
`ifdef MEMORY_SPRAM_BANKED_WB_BURST_EN
      w_err    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_rbank <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (w_acc_en && !w_acc_we) r_rbank <= w_acc_word[15:14];
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_bank
    if (i < BANKS) begin : g_inst
      logic w_cs;
      assign w_cs = w_acc_en && (w_acc_word[15:14] == 2'(i));
      memory_ice40_spram u_spram (
        .clk_i   (clk_i),
        .cs_i    (w_cs),
        .we_i    (w_acc_we),
        .addr_i  (w_acc_word[13:0]),
        .mask_i  (sel_i),
        .wdata_i (dat_i),
        .rdata_o (w_rdata[i])
      );
    end else begin : g_none
      assign w_rdata[i] = 32'h0;
    end
  end

  assign ack_o = w_ack;
  assign rty_o = 1'b0;
  assign dat_o = w_ack ? w_rdata[r_rbank] : 32'h0;
endmodule
`default_nettype wire

// File: tb/tb_memory_spram_banked_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_memory_spram_banked_wb: scoreboard bench for memory_spram_banked_wb     |
// | (BANKS=4). Revision: 1.0                                                   |
// +----------------------------------------------------------------------------+
module tb_memory_spram_banked_wb;
  localparam logic [31:0] BASE = 32'h0004_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [31:0] adr_i = 32'h0, dat_i = 32'h0;
  logic [3:0]  sel_i = 4'h0;
  logic [2:0]  cti_i = 3'h0;
  logic [1:0]  bte_i = 2'h0;
  logic [31:0] dat_o;
  logic        ack_o, err_o, rty_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc_cnt = 0;
  int err_seen = 0;

  logic [31:0] tx_adr [16];
  logic [31:0] tx_dat [16];
  logic [3:0]  tx_sel [16];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  int          ackc_q [$];
  logic [31:0] mem_m [logic [31:0]];

  memory_spram_banked_wb #(.BASE_ADDRESS(BASE), .BANKS(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .cti_i(cti_i), .bte_i(bte_i),
    .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk_i) if (err_o === 1'b1) err_seen <= err_seen + 1;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : 32'h0;
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = model_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    mem_m[a] = v;
  endfunction

  function automatic void clear_q();
    exp_q.delete(); got_q.delete(); ackc_q.delete();
  endfunction

  // Bus master: n beats from tx_* tables, as a burst or as single accesses.
  task automatic xfer(input int n, input bit burst, input bit wr,
                      output int nack, output int nerr, output int start, output bit tmo);
    int k, budget;
    k = 0; budget = 0; nack = 0; nerr = 0; tmo = 1'b0;
    @(posedge clk_i); #1;
    start = cyc_cnt;
    if (!wr) exp_q.push_back(model_rd(tx_adr[0]));
    while (k < n) begin
      cyc_i = 1'b1; stb_i = 1'b1; we_i = wr; bte_i = 2'b00;
      adr_i = tx_adr[k]; dat_i = tx_dat[k]; sel_i = tx_sel[k];
      cti_i = burst ? ((k == n - 1) ? 3'b111 : 3'b010) : 3'b000;
      @(negedge clk_i);
      budget++;
      if (err_o === 1'b1) begin
        nerr++;
        if (!wr) exp_q.delete(exp_q.size() - 1);
        break;
      end
      if (ack_o === 1'b1) begin
        nack++;
        ackc_q.push_back(cyc_cnt);
        if (wr) model_wr(tx_adr[k], tx_dat[k], tx_sel[k]);
        else got_q.push_back(dat_o);
        k++;
        if (k < n && !wr) exp_q.push_back(model_rd(tx_adr[k]));
      end
      if (budget >= 4 * n + 8) begin
        tmo = 1'b1;
        if (!wr && k < n) exp_q.delete(exp_q.size() - 1);
        break;
      end
      @(posedge clk_i); #1;
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic test_reset();
    int na, ne, st; bit tmo; logic [31:0] e, g;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tx_adr[0] = BASE + 20; tx_dat[0] = 32'h1234_5678; tx_sel[0] = 4'hF;
    xfer(1, 1'b0, 1'b1, na, ne, st, tmo);
    tx_adr[0] = BASE + 24; tx_dat[0] = 32'h5555_5555;
    xfer(1, 1'b0, 1'b1, na, ne, st, tmo);
    @(posedge clk_i); #1;
    rst_ni = 1'b0; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    adr_i = BASE + 20; dat_i = 32'hBAD0_BAD0; sel_i = 4'hF; cti_i = 3'b000;
    repeat (3) begin
      @(negedge clk_i);
      vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", ack_o); end
      vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_o); end
      vectors++; if (dat_o !== 32'h0) begin miscompares++; $display("FAIL reset_dat: got %h expected 0", dat_o); end
      vectors++; if (rty_o !== 1'b0) begin miscompares++; $display("FAIL reset_rty: got %b expected 0", rty_o); end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    // Write request whose acknowledge cycle is hit by reset must not commit.
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = BASE + 24; dat_i = 32'hAAAA_AAAA;
    @(posedge clk_i); #1 rst_ni = 1'b0;
    @(negedge clk_i);
    vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL reset_abort_ack: got %b expected 0", ack_o); end
    @(posedge clk_i); #1 rst_ni = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    clear_q();
    tx_adr[0] = BASE + 20; tx_adr[1] = BASE + 24;
    xfer(2, 1'b0, 1'b0, na, ne, st, tmo);
    vectors++; if (na !== 2) begin miscompares++; $display("FAIL reset_readback_acks: got %0d expected 2", na); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL reset_readback: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_single();
    int na, ne, st; bit tmo; logic [31:0] e;
    tx_adr[0] = BASE; tx_dat[0] = 32'hFFFF_FFFF; tx_sel[0] = 4'hF;
    xfer(1, 1'b0, 1'b1, na, ne, st, tmo);
    tx_dat[0] = 32'hDEAD_BEEF; tx_sel[0] = 4'b0101;
    xfer(1, 1'b0, 1'b1, na, ne, st, tmo);
    vectors++; if (na !== 1) begin miscompares++; $display("FAIL single_wr_ack: got %0d expected 1", na); end
    clear_q();
    exp_q.push_back(32'hFFAD_FFEF);
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = BASE; cti_i = 3'b000;
    @(negedge clk_i);
    vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL single_ack_n: got %b expected 0", ack_o); end
    @(negedge clk_i);
    vectors++; if (ack_o !== 1'b1) begin miscompares++; $display("FAIL single_ack_n1: got %b expected 1", ack_o); end
    e = exp_q.pop_front();
    vectors++; if (dat_o !== e) begin miscompares++; $display("FAIL single_rd_data: got %h expected %h", dat_o, e); end
    @(negedge clk_i);
    vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL single_ack_n2: got %b expected 0", ack_o); end
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic test_banks();
    int na, ne, st; bit tmo; logic [31:0] e, g;
    for (int i = 0; i < 4; i++) begin
      tx_adr[i] = BASE + 32'(i) * 32'h1_0000;
      tx_dat[i] = 32'h1111_1111 * 32'(i + 1);
      tx_sel[i] = 4'hF;
    end
    xfer(4, 1'b0, 1'b1, na, ne, st, tmo);
    vectors++; if (na !== 4) begin miscompares++; $display("FAIL banks_wr_acks: got %0d expected 4", na); end
    clear_q();
    xfer(4, 1'b0, 1'b0, na, ne, st, tmo);
    vectors++; if (na !== 4) begin miscompares++; $display("FAIL banks_rd_acks: got %0d expected 4", na); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL banks_rd_data: got %h expected %h", g, e); end
    end
    for (int j = 0; j < 2; j++) begin
      @(posedge clk_i); #1;
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; cti_i = 3'b000;
      adr_i = (j == 0) ? BASE - 32'd4 : BASE + 32'h4_0000;
      na = 0;
      repeat (6) begin
        @(negedge clk_i);
        if (ack_o !== 1'b0 || err_o !== 1'b0) na++;
      end
      vectors++; if (na !== 0) begin miscompares++; $display("FAIL banks_outside_%0d: got %0d responses expected 0", j, na); end
      cyc_i = 1'b0; stb_i = 1'b0;
    end
  endtask

  task automatic test_burst();
    int na, ne, st, stride; bit tmo; logic [31:0] e, g;
`ifdef MEMORY_SPRAM_BANKED_WB_BURST_EN
    stride = 1;
`else
    stride = 2;
`endif
    err_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tx_adr[i] = BASE + 32'(4 * i); tx_dat[i] = 32'(i); tx_sel[i] = 4'hF;
    end
    xfer(8, 1'b1, 1'b1, na, ne, st, tmo);
    vectors++; if (na !== 8) begin miscompares++; $display("FAIL burst_wr_acks: got %0d expected 8", na); end
    clear_q();
    xfer(8, 1'b1, 1'b0, na, ne, st, tmo);
    vectors++; if (na !== 8 || tmo !== 1'b0) begin miscompares++; $display("FAIL burst_rd_acks: got %0d (timeout %b) expected 8", na, tmo); end
    for (int k = 0; k < 8 && k < ackc_q.size(); k++) begin
      vectors++;
      if (ackc_q[k] !== st + 1 + k * stride) begin
        miscompares++; $display("FAIL burst_ack_cycle[%0d]: got %0d expected %0d", k, ackc_q[k] - st, 1 + k * stride);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL burst_rd_data: got %h expected %h", g, e); end
    end
    clear_q();
    tx_adr[0] = BASE + 12;
    xfer(1, 1'b0, 1'b0, na, ne, st, tmo);
    vectors++; if (na !== 1 || ackc_q.size() == 0 || ackc_q[0] !== st + 1) begin
      miscompares++; $display("FAIL burst_then_single: got %0d acks expected 1 at cycle +1", na);
    end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 32'h3;
    g = got_q.size() > 0 ? got_q.pop_front() : 32'hX;
    vectors++; if (g !== e) begin miscompares++; $display("FAIL burst_then_single_data: got %h expected %h", g, e); end
    vectors++; if (err_seen !== 0) begin miscompares++; $display("FAIL burst_err: got %0d err cycles expected 0", err_seen); end
  endtask

  task automatic test_burst_end();
    int na, ne, st; bit tmo; logic [31:0] e, g;
    tx_adr[0] = BASE + 32'h3_FFFC; tx_dat[0] = 32'hCAFE_F00D; tx_sel[0] = 4'hF;
    xfer(1, 1'b0, 1'b1, na, ne, st, tmo);
    tx_adr[1] = BASE + 32'h4_0000; tx_adr[2] = BASE + 32'h4_0004;
    tx_dat[0] = 32'h0BAD_F00D; tx_dat[1] = 32'h7777_7777; tx_dat[2] = 32'h8888_8888;
    tx_sel[1] = 4'hF; tx_sel[2] = 4'hF;
    clear_q();
`ifdef MEMORY_SPRAM_BANKED_WB_BURST_EN
    xfer(3, 1'b1, 1'b1, na, ne, st, tmo);
    vectors++; if (na !== 1 || ne !== 1) begin miscompares++; $display("FAIL end_wr_burst: got %0d acks %0d errs expected 1 1", na, ne); end
    clear_q();
    xfer(3, 1'b1, 1'b0, na, ne, st, tmo);
    vectors++; if (na !== 1 || ne !== 1) begin miscompares++; $display("FAIL end_rd_burst: got %0d acks %0d errs expected 1 1", na, ne); end
`else
    err_seen = 0;
    xfer(2, 1'b1, 1'b0, na, ne, st, tmo);
    vectors++; if (na !== 1 || tmo !== 1'b1) begin miscompares++; $display("FAIL end_rd_single: got %0d acks timeout %b expected 1 1", na, tmo); end
    vectors++; if (err_seen !== 0) begin miscompares++; $display("FAIL end_err: got %0d err cycles expected 0", err_seen); end
`endif
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL end_last_word: got %h expected %h", g, e); end
    end
    clear_q();
    tx_adr[0] = BASE;
    xfer(1, 1'b0, 1'b0, na, ne, st, tmo);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 32'h0;
    g = got_q.size() > 0 ? got_q.pop_front() : 32'hX;
    vectors++; if (g !== e) begin miscompares++; $display("FAIL end_no_wrap_write: got %h expected %h", g, e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_banks();
    test_burst();
    test_burst_end();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
